// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the byte-serial memory controller: data widths,
// access-width codes, FSM encoding and requester ownership.
package mem_ctrl_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    WID_BYTE  = 2'd0,
    WID_HALF  = 2'd1,
    WID_WORD  = 2'd2,
    WID_WORD3 = 2'd3
  } width_e;

  typedef enum logic {
    OWN_MEM = 1'b0,
    OWN_IF  = 1'b1
  } owner_e;

  function automatic logic [2:0] nbytes(input width_e w);
    case (w)
      WID_BYTE: nbytes = 3'd1;
      WID_HALF: nbytes = 3'd2;
      default:  nbytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl_load_ext.sv
// Load result extension: byte/half zero- or sign-extended, word passed through.
module load_ext
  import mem_ctrl_pkg::*;
(
  input  logic [XLEN-1:0] data_i,
  input  width_e          width_i,
  input  logic            sext_i,
  output logic [XLEN-1:0] result_o
);

  always_comb begin
    case (width_i)
      WID_BYTE: result_o = {{24{sext_i & data_i[7]}}, data_i[7:0]};
      WID_HALF: result_o = {{16{sext_i & data_i[15]}}, data_i[15:0]};
      default:  result_o = data_i;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating a MEM (load/store) port and an
// IF (instruction fetch) port onto an 8-bit RAM with one-cycle read latency.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [XLEN-1:0]   mem_addr_i,
  input  logic [XLEN-1:0]   mem_wdata_i,
  input  logic [1:0]        mem_width_i,
  input  logic              mem_sext_i,
  output logic              mem_done_o,
  output logic [XLEN-1:0]   mem_rdata_o,
  output logic              mem_busy_o,
  input  logic              if_req_i,
  input  logic [XLEN-1:0]   if_addr_i,
  output logic              if_done_o,
  output logic [XLEN-1:0]   if_inst_o,
  input  logic [BYTE_W-1:0] ram_din_i,
  output logic [BYTE_W-1:0] ram_dout_o,
  output logic [XLEN-1:0]   ram_a_o,
  output logic              ram_wr_o
);

  state_e          state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  width_e          width_q, width_d;
  logic            sext_q, sext_d;
  owner_e          own_q, own_d;
  logic [XLEN-1:0] rbuf_q, rbuf_d;
  logic [XLEN-1:0] mem_rdata_q, mem_rdata_d;
  logic [XLEN-1:0] if_inst_q, if_inst_d;

  logic [XLEN-1:0] ld_word;
  logic [XLEN-1:0] ext_word;
  logic [2:0]      nb;
  logic [2:0]      a_off;
  logic [1:0]      byte_idx;

  load_ext u_load_ext (
    .data_i   (ld_word),
    .width_i  (width_q),
    .sext_i   (sext_q),
    .result_o (ext_word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      width_q     <= WID_BYTE;
      sext_q      <= 1'b0;
      own_q       <= OWN_MEM;
      rbuf_q      <= '0;
      mem_rdata_q <= '0;
      if_inst_q   <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      width_q     <= width_d;
      sext_q      <= sext_d;
      own_q       <= own_d;
      rbuf_q      <= rbuf_d;
      mem_rdata_q <= mem_rdata_d;
      if_inst_q   <= if_inst_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    width_d     = width_q;
    sext_d      = sext_q;
    own_d       = own_q;
    rbuf_d      = rbuf_q;
    mem_rdata_d = mem_rdata_q;
    if_inst_d   = if_inst_q;

    nb       = nbytes(width_q);
    byte_idx = cnt_q[1:0] - 2'd1;
    ld_word  = rbuf_q;
    if (state_q == ST_READ && cnt_q != 3'd0)
      ld_word[{byte_idx, 3'b000} +: 8] = ram_din_i;

    // While frozen mid-load, re-present the previous byte address so the RAM
    // keeps returning the byte still owed to the capture on resume.
    a_off = (state_q == ST_READ && !rdy && cnt_q != 3'd0) ? cnt_q - 3'd1 : cnt_q;

    ram_a_o    = '0;
    ram_dout_o = '0;
    ram_wr_o   = 1'b0;
    mem_done_o = 1'b0;
    if_done_o  = 1'b0;
    case (state_q)
      ST_READ:  ram_a_o = addr_q + {29'd0, a_off};
      ST_WRITE: begin
        ram_a_o    = addr_q + {29'd0, a_off};
        ram_dout_o = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
        ram_wr_o   = rdy;
      end
      ST_DONE: begin
        mem_done_o = rdy && (own_q == OWN_MEM);
        if_done_o  = rdy && (own_q == OWN_IF);
      end
      default: ;
    endcase

    if (rdy) begin
      case (state_q)
        ST_IDLE: begin
          cnt_d  = '0;
          rbuf_d = '0;
          if (mem_req_i) begin
            addr_d  = mem_addr_i;
            wdata_d = mem_wdata_i;
            width_d = width_e'(mem_width_i);
            sext_d  = mem_sext_i;
            own_d   = OWN_MEM;
            state_d = mem_we_i ? ST_WRITE : ST_READ;
          end else if (if_req_i) begin
            addr_d  = if_addr_i;
            wdata_d = '0;
            width_d = WID_WORD;
            sext_d  = 1'b0;
            own_d   = OWN_IF;
            state_d = ST_READ;
          end
        end
        ST_READ: begin
          cnt_d  = cnt_q + 3'd1;
          rbuf_d = ld_word;
          if (cnt_q == nb) begin
            state_d = ST_DONE;
            cnt_d   = '0;
            if (own_q == OWN_MEM) mem_rdata_d = ext_word;
            else                  if_inst_d   = ext_word;
          end
        end
        ST_WRITE: begin
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == nb - 3'd1) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign mem_busy_o  = (state_q != ST_IDLE);
  assign mem_rdata_o = mem_rdata_q;
  assign if_inst_o   = if_inst_q;

endmodule
